// File: rtl/tug_field.sv
// Tug-of-war playfield: conditions two raw buttons into press pulses and walks
// a single lit position along an N-light bar, freezing it once a win press lands.
module tug_field #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         KEY_L,
    input  logic         KEY_R,
    input  logic         nextRound,
    output logic         PL,
    output logic         PR,
    output logic [N-1:0] lights,
    output logic         edgelight_L,
    output logic         edgelight_R
);

    localparam int C = (N - 1) / 2;
    localparam logic [N-1:0] CENTER_POS = {{(N-1){1'b0}}, 1'b1} << C;

    typedef enum logic [0:0] {
        PLAY = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bit 0 is the first sampling flop, bit 2 the oldest sample.
    logic [2:0]   sync_l_r;
    logic [2:0]   sync_r_r;
    logic         pl_s;
    logic         pr_s;
    logic [N-1:0] pos_r;
    logic [N-1:0] pos_nxt_s;
    state_t       state_r;
    state_t       state_nxt_s;

    // Button synchronizer chains; preset to 1 so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_l_r <= 3'b111;
            sync_r_r <= 3'b111;
        end else begin
            sync_l_r <= {sync_l_r[1:0], KEY_L};
            sync_r_r <= {sync_r_r[1:0], KEY_R};
        end
    end

    assign pl_s = sync_l_r[1] & ~sync_l_r[2];
    assign pr_s = sync_r_r[1] & ~sync_r_r[2];

    // Next position and state; a round restart outranks any press in the same cycle.
    always_comb begin
        pos_nxt_s   = pos_r;
        state_nxt_s = state_r;
        if (nextRound) begin
            pos_nxt_s   = CENTER_POS;
            state_nxt_s = PLAY;
        end else begin
            case (state_r)
                PLAY: begin
                    if (pl_s && pr_s) begin
                        pos_nxt_s = pos_r;
                    end else if (pl_s) begin
                        if (pos_r[N-1]) begin
                            state_nxt_s = HOLD;
                        end else begin
                            pos_nxt_s = {pos_r[N-2:0], 1'b0};
                        end
                    end else if (pr_s) begin
                        if (pos_r[0]) begin
                            state_nxt_s = HOLD;
                        end else begin
                            pos_nxt_s = {1'b0, pos_r[N-1:1]};
                        end
                    end else begin
                        pos_nxt_s = pos_r;
                    end
                end
                HOLD: begin
                    pos_nxt_s = pos_r;
                end
                default: begin
                    pos_nxt_s   = CENTER_POS;
                    state_nxt_s = PLAY;
                end
            endcase
        end
    end

    // Position and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_r   <= CENTER_POS;
            state_r <= PLAY;
        end else begin
            pos_r   <= pos_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    assign PL          = pl_s;
    assign PR          = pr_s;
    assign lights      = pos_r;
    assign edgelight_L = pos_r[N-1];
    assign edgelight_R = pos_r[0];

endmodule

// File: tb/tb_tug_field.sv
// Directed bench for tug_field (N=9): reset behaviour, pressing, win hold,
// round restart, simultaneous presses and mid-round reset.
module tb_tug_field;

    logic       clk;
    logic       rst;
    logic       key_l;
    logic       key_r;
    logic       next_round;
    logic       pl;
    logic       pr;
    logic [8:0] lights;
    logic       edge_l;
    logic       edge_r;

    int checks;
    int failures;

    tug_field #(.N(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .KEY_L      (key_l),
        .KEY_R      (key_r),
        .nextRound  (next_round),
        .PL         (pl),
        .PR         (pr),
        .lights     (lights),
        .edgelight_L(edge_l),
        .edgelight_R(edge_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive keys at a falling edge; returns at the falling edge where the pulse is visible.
    task automatic press_start(input logic l, input logic r);
        @(negedge clk);
        key_l = l;
        key_r = r;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Let the move land, release keys and keep them low long enough to re-arm.
    task automatic press_finish();
        @(negedge clk);
        key_l = 1'b0;
        key_r = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst   = 1'b1;
        key_l = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (lights !== 9'b000010000) begin
            failures++;
            $display("FAIL reset_lights got=%b exp=%b", lights, 9'b000010000);
        end
        checks++;
        if ({pl, pr, edge_l, edge_r} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b", {pl, pr, edge_l, edge_r}, 4'b0000);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (pl !== 1'b0) begin
                failures++;
                $display("FAIL held_no_pulse cyc=%0d got=%b exp=0", i, pl);
            end
        end
        checks++;
        if (lights !== 9'b000010000) begin
            failures++;
            $display("FAIL held_lights got=%b exp=%b", lights, 9'b000010000);
        end
        key_l = 1'b0;
        repeat (2) @(negedge clk);
        key_l = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pl !== 1'b1 || lights !== 9'b000010000) begin
            failures++;
            $display("FAIL rearm_pulse got pl=%b lights=%b exp pl=1 lights=%b", pl, lights, 9'b000010000);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pl !== 1'b0 || lights !== 9'b000100000) begin
                failures++;
                $display("FAIL rearm_single cyc=%0d got pl=%b lights=%b exp pl=0 lights=%b", i, pl, lights, 9'b000100000);
            end
        end
        key_l = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_to_left_edge();
        logic [8:0] exp_tab [4];
        exp_tab[0] = 9'b000100000;
        exp_tab[1] = 9'b001000000;
        exp_tab[2] = 9'b010000000;
        exp_tab[3] = 9'b100000000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            press_start(1'b1, 1'b0);
            press_finish();
            checks++;
            if (lights !== exp_tab[i]) begin
                failures++;
                $display("FAIL left_step%0d got=%b exp=%b", i, lights, exp_tab[i]);
            end
        end
        checks++;
        if (edge_l !== 1'b1 || edge_r !== 1'b0) begin
            failures++;
            $display("FAIL left_edge_flag got=%b%b exp=10", edge_l, edge_r);
        end
        press_start(1'b1, 1'b0);
        checks++;
        if (pl !== 1'b1 || edge_l !== 1'b1) begin
            failures++;
            $display("FAIL win_press got pl=%b edge_l=%b exp 1 1", pl, edge_l);
        end
        press_finish();
        checks++;
        if (lights !== 9'b100000000) begin
            failures++;
            $display("FAIL win_hold got=%b exp=%b", lights, 9'b100000000);
        end
        press_start(1'b0, 1'b1);
        checks++;
        if (pr !== 1'b1) begin
            failures++;
            $display("FAIL hold_pr_pulse got=%b exp=1", pr);
        end
        press_finish();
        checks++;
        if (lights !== 9'b100000000) begin
            failures++;
            $display("FAIL hold_frozen got=%b exp=%b", lights, 9'b100000000);
        end
    endtask

    task automatic test_next_round();
        @(negedge clk);
        next_round = 1'b1;
        @(negedge clk);
        next_round = 1'b0;
        checks++;
        if (lights !== 9'b000010000 || edge_l !== 1'b0) begin
            failures++;
            $display("FAIL next_round got lights=%b edge_l=%b exp %b 0", lights, edge_l, 9'b000010000);
        end
        press_start(1'b0, 1'b1);
        press_finish();
        checks++;
        if (lights !== 9'b000001000) begin
            failures++;
            $display("FAIL after_round_move got=%b exp=%b", lights, 9'b000001000);
        end
    endtask

    task automatic test_simultaneous();
        press_start(1'b1, 1'b1);
        checks++;
        if ({pl, pr} !== 2'b11) begin
            failures++;
            $display("FAIL both_pulse got=%b exp=11", {pl, pr});
        end
        press_finish();
        checks++;
        if (lights !== 9'b000001000) begin
            failures++;
            $display("FAIL both_cancel got=%b exp=%b", lights, 9'b000001000);
        end
    endtask

    task automatic test_round_priority();
        for (int i = 0; i < 2; i++) begin
            press_start(1'b0, 1'b1);
            press_finish();
        end
        checks++;
        if (lights !== 9'b000000010) begin
            failures++;
            $display("FAIL reach_idx1 got=%b exp=%b", lights, 9'b000000010);
        end
        press_start(1'b0, 1'b1);
        checks++;
        if (pr !== 1'b1) begin
            failures++;
            $display("FAIL prio_pulse got=%b exp=1", pr);
        end
        next_round = 1'b1;
        @(negedge clk);
        next_round = 1'b0;
        checks++;
        if (lights !== 9'b000010000) begin
            failures++;
            $display("FAIL round_priority got=%b exp=%b", lights, 9'b000010000);
        end
        key_r = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rst_mid_round();
        for (int i = 0; i < 4; i++) begin
            press_start(1'b0, 1'b1);
            press_finish();
        end
        checks++;
        if (lights !== 9'b000000001 || edge_r !== 1'b1) begin
            failures++;
            $display("FAIL right_edge got lights=%b edge_r=%b exp %b 1", lights, edge_r, 9'b000000001);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (lights !== 9'b000010000 || {edge_l, edge_r} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset got lights=%b edges=%b exp %b 00", lights, {edge_l, edge_r}, 9'b000010000);
        end
        press_start(1'b1, 1'b0);
        press_finish();
        checks++;
        if (lights !== 9'b000100000) begin
            failures++;
            $display("FAIL post_reset_play got=%b exp=%b", lights, 9'b000100000);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        key_l      = 1'b0;
        key_r      = 1'b0;
        next_round = 1'b0;
        test_reset();
        test_to_left_edge();
        test_next_round();
        test_simultaneous();
        test_round_priority();
        test_rst_mid_round();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
